// File: rtl/pixel_fifo_param.sv
// pixel_fifo_param
//   Synchronous pixel FIFO between the bus-read engine (writer) and the video
//   output stage (reader). Each entry is NUM_CH packed channels of CH_W bits;
//   channel k sits at [k*CH_W +: CH_W].
//   Ports:
//     clk, reset_n (async, active-low), flush (sync clear of contents)
//     wr_en/wr_data             : write side
//     rd_en/rd_data/rd_valid    : read side (registered or first-word-fall-through)
//     level/full/empty          : occupancy
//     lo_thresh/hi_thresh       : runtime watermarks -> almost_empty/almost_full
//     overflow/underflow        : sticky error flags, cleared by clr_flags
module pixel_fifo_param #(
  parameter  int CH_W   = 8,
  parameter  int NUM_CH = 3,
  parameter  int DEPTH  = 16,
  parameter  int FWFT   = 0,
  localparam int DW     = CH_W * NUM_CH,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic [AW:0]   lo_thresh,
  input  logic [AW:0]   hi_thresh,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow,
  input  logic          clr_flags
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr, r_rd_ptr;
  logic          r_ovf, r_unf;

  logic [AW:0]   w_level;
  logic          w_full, w_empty;
  logic          w_wr_acc, w_rd_acc;
  logic          w_ovf_set, w_unf_set;
  logic [AW-1:0] w_rd_idx;

  // Pointers carry one extra wrap bit, so the plain difference is the level
  // and full (DEPTH) is distinguishable from empty (0).
  assign w_level  = r_wr_ptr - r_rd_ptr;
  assign w_full   = (w_level == (AW+1)'(DEPTH));
  assign w_empty  = (w_level == '0);
  assign w_rd_idx = r_rd_ptr[AW-1:0];

  // Flush takes priority: requests in a flush cycle are dropped and set no flags.
  assign w_wr_acc  = wr_en & ~w_full  & ~flush;
  assign w_rd_acc  = rd_en & ~w_empty & ~flush;
  assign w_ovf_set = wr_en & w_full   & ~flush;
  assign w_unf_set = rd_en & w_empty  & ~flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; only entries between the pointers are ever observed.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

  // Sticky error flags: a new event in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (clr_flags) r_ovf <= 1'b0;
      if (w_unf_set)      r_unf <= 1'b1;
      else if (clr_flags) r_unf <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is presented combinationally; forced to zero when empty so
      // the output is clean out of reset and after a flush.
      assign rd_data  = w_empty ? '0 : r_mem[w_rd_idx];
      assign rd_valid = ~w_empty;
    end else begin : g_reg
      logic [DW-1:0] r_rd_data;
      logic          r_rd_valid;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else begin
          r_rd_valid <= w_rd_acc;
          if (w_rd_acc) r_rd_data <= r_mem[w_rd_idx];
        end
      end
      assign rd_data  = r_rd_data;
      assign rd_valid = r_rd_valid;
    end
  endgenerate

  assign level        = w_level;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (w_level >= hi_thresh);
  assign almost_empty = (w_level <= lo_thresh);
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_pixel_fifo_param.sv
// tb_pixel_fifo_param
//   Drives a registered-read FIFO (dut0) and a FWFT FIFO (dut1) with the same
//   stimulus. A queue-based reference model predicts level, flags and read
//   data each cycle; a vector table and hand-written sequences cover the
//   flag corner cases, flush, thresholds and asynchronous reset.
module tb_pixel_fifo_param;
  localparam int DEPTH = 16;
  localparam int DW    = 24;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset_n, flush, wr_en, rd_en, clr_flags;
  logic [DW-1:0] wr_data;
  logic [AW:0]   lo_thresh, hi_thresh;

  logic [DW-1:0] rd_data0, rd_data1;
  logic          rd_valid0, rd_valid1;
  logic [AW:0]   level0, level1;
  logic          full0, full1, empty0, empty1, af0, af1, ae0, ae1;
  logic          ovf0, ovf1, unf0, unf1;

  pixel_fifo_param #(.CH_W(8), .NUM_CH(3), .DEPTH(DEPTH), .FWFT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data0), .rd_valid(rd_valid0), .lo_thresh(lo_thresh),
    .hi_thresh(hi_thresh), .level(level0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .overflow(ovf0), .underflow(unf0),
    .clr_flags(clr_flags));

  pixel_fifo_param #(.CH_W(8), .NUM_CH(3), .DEPTH(DEPTH), .FWFT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data1), .rd_valid(rd_valid1), .lo_thresh(lo_thresh),
    .hi_thresh(hi_thresh), .level(level1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .overflow(ovf1), .underflow(unf1),
    .clr_flags(clr_flags));

  always #5 clk = ~clk;

  // reference model
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd;
  bit            m_rv, m_ovf, m_unf;
  int            n_chk, n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int lvl = q.size();
    chk("level",        32'(level0), 32'(lvl));
    chk("level_fwft",   32'(level1), 32'(lvl));
    chk("full",         32'(full0),  32'(lvl == DEPTH));
    chk("empty",        32'(empty0), 32'(lvl == 0));
    chk("almost_full",  32'(af0),    32'(lvl >= int'(hi_thresh)));
    chk("almost_empty", 32'(ae0),    32'(lvl <= int'(lo_thresh)));
    chk("overflow",     32'(ovf0),   32'(m_ovf));
    chk("underflow",    32'(unf0),   32'(m_unf));
    chk("rd_valid",     32'(rd_valid0), 32'(m_rv));
    chk("rd_data",      32'(rd_data0),  32'(m_rd));
    chk("rd_valid_fwft", 32'(rd_valid1), 32'(lvl != 0));
    if (lvl != 0) chk("rd_data_fwft", 32'(rd_data1), 32'(q[0]));
  endtask

  // One clock: predict from pre-edge state, advance, then compare.
  task automatic tick();
    int  lvl = q.size();
    bit  mf = (lvl == DEPTH), me = (lvl == 0);
    bit  wa = wr_en && !mf && !flush;
    bit  ra = rd_en && !me && !flush;
    m_rv = ra;
    if (ra) m_rd = q.pop_front();
    if (wa) q.push_back(wr_data);
    if (flush) q.delete();
    if (clr_flags) begin m_ovf = 0; m_unf = 0; end
    if (wr_en && mf && !flush) m_ovf = 1;
    if (rd_en && me && !flush) m_unf = 1;
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic drive(input bit w, input bit r, input bit f, input bit c, input logic [DW-1:0] d);
    wr_en = w; rd_en = r; flush = f; clr_flags = c; wr_data = d;
  endtask

  typedef struct {
    bit w, r, f, c;
    logic [DW-1:0] d;
    int  exp_level;
    bit  exp_unf, exp_rv;
  } vec_t;
  vec_t vt[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    m_rd = '0; m_rv = 0; m_ovf = 0; m_unf = 0;
    reset_n = 1'b0; lo_thresh = 5'd2; hi_thresh = 5'd14;
    drive(0, 0, 0, 0, '0);
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_ae", 32'(ae0), 32'd1);
    reset_n = 1'b1;

    // Underflow / flush corner cases from empty, with explicit expectations.
    vt[0] = '{0,1,0,0,24'h0,    0,1,0};  // read on empty -> underflow
    vt[1] = '{1,1,0,0,24'hA1,   1,1,0};  // wr&rd on empty: write only
    vt[2] = '{0,0,0,1,24'h0,    1,0,0};  // clear
    vt[3] = '{0,1,0,0,24'h0,    0,0,1};  // good read
    vt[4] = '{1,1,0,1,24'hA2,   1,1,0};  // set wins over clear
    vt[5] = '{0,0,0,1,24'h0,    1,0,0};
    vt[6] = '{0,1,1,0,24'h0,    0,0,0};  // flush drops the read
    vt[7] = '{0,1,1,0,24'h0,    0,0,0};  // flush on empty: no underflow
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].w, vt[i].r, vt[i].f, vt[i].c, vt[i].d);
      tick();
      chk("vec_level", 32'(level0), 32'(vt[i].exp_level));
      chk("vec_unf",   32'(unf0),   32'(vt[i].exp_unf));
      chk("vec_rv",    32'(rd_valid0), 32'(vt[i].exp_rv));
      if (i == 3) chk("vec_rd_data", 32'(rd_data0), 32'hA1);
    end

    // Fill to full.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 0, 0, 24'h050A0F + DW'(i));
      tick();
    end
    drive(0, 0, 0, 0, '0); tick();
    chk("fill_full", 32'(full0), 32'd1);
    chk("fill_level", 32'(level0), 32'd16);
    chk("fill_af", 32'(af0), 32'd1);
    hi_thresh = 5'd17; #1;
    chk("hi_above_depth_af", 32'(af0), 32'd0);
    hi_thresh = 5'd14;

    // Overflow, clear, and set-wins-over-clear.
    drive(1, 0, 0, 0, 24'hFFFFFF); tick();
    chk("ovf_set", 32'(ovf0), 32'd1);
    chk("ovf_level", 32'(level0), 32'd16);
    drive(0, 0, 0, 1, '0); tick();
    chk("ovf_clr", 32'(ovf0), 32'd0);
    drive(1, 0, 0, 1, 24'hFFFFFF); tick();
    chk("ovf_set_wins", 32'(ovf0), 32'd1);
    drive(0, 0, 0, 1, '0); tick();

    // Drain all 16, each read checked against the model queue.
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1, 0, 0, '0); tick();
      chk("drain_order", 32'(rd_data0), 32'h050A0F + 32'(i));
    end
    drive(0, 0, 0, 0, '0); tick();
    chk("drain_empty", 32'(empty0), 32'd1);
    chk("drain_rv_low", 32'(rd_valid0), 32'd0);

    // At full, wr&rd: read wins, write rejected, overflow sets.
    for (int i = 0; i < DEPTH; i++) begin drive(1, 0, 0, 0, DW'(32'h300 + i)); tick(); end
    drive(1, 1, 0, 0, 24'hDEAD01); tick();
    chk("full_wrrd_level", 32'(level0), 32'd15);
    chk("full_wrrd_ovf", 32'(ovf0), 32'd1);
    drive(0, 0, 0, 1, '0); tick();
    for (int i = 0; i < 7; i++) begin drive(0, 1, 0, 0, '0); tick(); end
    chk("to_level8", 32'(level0), 32'd8);

    // Steady-state streaming: pointers wrap repeatedly at constant level.
    for (int i = 0; i < 40; i++) begin
      drive(1, 1, 0, 0, DW'(32'h100 + i)); tick();
      chk("stream_level", 32'(level0), 32'd8);
    end
    drive(0, 0, 0, 0, '0); tick();
    for (int i = 0; i < 8; i++) begin drive(0, 1, 0, 0, '0); tick(); end
    chk("stream_tail", 32'(rd_data0), 32'h100 + 32'd39);
    drive(0, 0, 0, 0, '0); tick();

    // FWFT single entry.
    drive(1, 0, 0, 0, 24'h112233); tick();
    chk("fwft_valid", 32'(rd_valid1), 32'd1);
    chk("fwft_data", 32'(rd_data1), 32'h112233);
    drive(0, 1, 0, 0, '0); tick();
    chk("fwft_empty", 32'(empty1), 32'd1);
    chk("fwft_valid_low", 32'(rd_valid1), 32'd0);
    hi_thresh = 5'd0; #1;
    chk("hi_zero_af", 32'(af0), 32'd1);
    hi_thresh = 5'd14;

    // Flush at level 9 with a concurrent write; sticky flags retained.
    drive(1, 0, 0, 0, 24'h0); tick();
    drive(0, 1, 0, 0, '0); tick();
    drive(0, 1, 0, 0, '0); tick();          // underflow on empty
    for (int i = 0; i < 9; i++) begin drive(1, 0, 0, 0, DW'(32'h500 + i)); tick(); end
    chk("pre_flush_level", 32'(level0), 32'd9);
    drive(1, 0, 1, 0, 24'h777777); tick();
    chk("flush_level", 32'(level0), 32'd0);
    chk("flush_empty", 32'(empty0), 32'd1);
    chk("flush_keeps_unf", 32'(unf0), 32'd1);

    // Asynchronous reset in the middle of a write burst.
    for (int i = 0; i < 5; i++) begin drive(1, 0, 0, 0, DW'(32'h600 + i)); tick(); end
    #2 reset_n = 1'b0;
    #1;
    q.delete(); m_rd = '0; m_rv = 0; m_ovf = 0; m_unf = 0;
    check_all();
    chk("areset_rd_data", 32'(rd_data0), 32'd0);
    drive(0, 0, 0, 0, '0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    drive(1, 0, 0, 0, 24'hABCDEF); tick();
    drive(1, 0, 0, 0, 24'h123456); tick();
    drive(0, 1, 0, 0, '0); tick();
    chk("post_reset_first", 32'(rd_data0), 32'hABCDEF);
    drive(0, 0, 0, 0, '0); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
